// File: rtl/sw_defs.sv
// Shared stopwatch definitions: field widths, default moduli and the packed
// time record. Used by the datapath here and by the FND display decoder.
package sw_defs;

  // Fixed field widths of the time outputs.
  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  // Default moduli of each field.
  localparam int MSEC_MAX_DEF = 100;
  localparam int SEC_MAX_DEF  = 60;
  localparam int MIN_MAX_DEF  = 60;
  localparam int HOUR_MAX_DEF = 24;

  // Complete time value as consumed by the display stage.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } sw_time_t;

  // Number of clk cycles per centisecond tick.
  function automatic int div_ratio(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// Clock divider with run/clear gating.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   run_stop     1 = divider advances, 0 = divider holds (keeps fractional period)
//   clear        synchronous clear; zeroes the divider and suppresses the tick
//   tick_en      combinational: asserted on the edge where the count advances
module sw_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run_stop,
  input  logic clear,
  output logic tick_en
);

  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div;
  logic             at_last;

  assign at_last = (div == DIV_LAST);
  assign tick_en = run_stop & at_last & ~clear;

  // Holding while stopped means a stop on the last count leaves div at
  // DIV-1, so the tick fires on the very first edge after resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (clear) begin
      div <= '0;
    end else if (run_stop) begin
      div <= at_last ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sw_time_counter.sv
// One modulo-MAX field of the time cascade.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      synchronous clear to 0 (priority over inc)
//   inc        advance by one this edge
//   cnt        registered count 0..MAX-1
//   carry      combinational: inc while at MAX-1, drives the next field's inc
module sw_time_counter #(
  parameter int WIDTH = 7,
  parameter int MAX   = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             carry
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic at_last;

  assign at_last = (cnt == LAST);
  // Combinational carry lets the whole cascade roll over on a single edge.
  assign carry   = inc & at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_last ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch time-keeping datapath: divides clk to TICK_HZ and counts a
// centisecond/second/minute/hour cascade for the FND display stage.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   run_stop   level from controller, 1 = counting
//   clear      one-cycle clear pulse from controller
//   msec/sec/min/hour  registered binary time fields
//   tick       registered one-cycle pulse per msec increment
module stopwatch_datapath
  import sw_defs::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int MSEC_MAX = MSEC_MAX_DEF,
  parameter int SEC_MAX  = SEC_MAX_DEF,
  parameter int MIN_MAX  = MIN_MAX_DEF,
  parameter int HOUR_MAX = HOUR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_stop,
  input  logic              clear,
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              tick
);

  localparam int DIV = div_ratio(CLK_HZ, TICK_HZ);

  logic tick_en;
  logic msec_carry;
  logic sec_carry;
  logic min_carry;
  logic hour_carry_unused;  // day rollover is silent: no overflow flag

  sw_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .run_stop(run_stop),
    .clear   (clear),
    .tick_en (tick_en)
  );

  sw_time_counter #(
    .WIDTH(MSEC_W),
    .MAX  (MSEC_MAX)
  ) u_msec (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .inc  (tick_en),
    .cnt  (msec),
    .carry(msec_carry)
  );

  sw_time_counter #(
    .WIDTH(SEC_W),
    .MAX  (SEC_MAX)
  ) u_sec (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .inc  (msec_carry),
    .cnt  (sec),
    .carry(sec_carry)
  );

  sw_time_counter #(
    .WIDTH(MIN_W),
    .MAX  (MIN_MAX)
  ) u_min (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .inc  (sec_carry),
    .cnt  (min),
    .carry(min_carry)
  );

  sw_time_counter #(
    .WIDTH(HOUR_W),
    .MAX  (HOUR_MAX)
  ) u_hour (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .inc  (min_carry),
    .cnt  (hour),
    .carry(hour_carry_unused)
  );

  // tick_en already excludes clear, so a cleared edge leaves tick low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= tick_en;
    end
  end

endmodule

// File: tb/tb_stopwatch_datapath.sv
module tb_stopwatch_datapath;

  logic       clk;
  logic       rst;
  logic       run_stop;
  logic       clear;
  logic [6:0] msec, s_msec;
  logic [5:0] sec, s_sec;
  logic [5:0] min, s_min;
  logic [4:0] hour, s_hour;
  logic       tick, s_tick;

  // Main instance: DIV = 10, real moduli.
  stopwatch_datapath #(
    .CLK_HZ(1000), .TICK_HZ(100)
  ) dut (
    .clk(clk), .rst(rst), .run_stop(run_stop), .clear(clear),
    .msec(msec), .sec(sec), .min(min), .hour(hour), .tick(tick)
  );

  // Reduced instance: DIV = 2, moduli 4/3/2/2 so a full-day wrap fits in 96 edges.
  stopwatch_datapath #(
    .CLK_HZ(200), .TICK_HZ(100),
    .MSEC_MAX(4), .SEC_MAX(3), .MIN_MAX(2), .HOUR_MAX(2)
  ) dut_s (
    .clk(clk), .rst(rst), .run_stop(run_stop), .clear(clear),
    .msec(s_msec), .sec(s_sec), .min(s_min), .hour(s_hour), .tick(s_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int div;
    int msec;
    int sec;
    int min;
    int hour;
    int tick;
  } mstate_t;

  typedef struct {
    mstate_t m;
    mstate_t s;
  } exp_t;

  exp_t    exp_q[$];
  mstate_t cur_m, cur_s;
  int      n_cmp = 0;
  int      n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one rising edge.
  function automatic mstate_t nxt(input mstate_t s, input int dv, input int mm,
                                  input int sm, input int nm, input int hm,
                                  input bit run, input bit clr);
    mstate_t n = s;
    n.tick = 0;
    if (clr) begin
      n = '{default: 0};
    end else if (run) begin
      if (s.div == dv - 1) begin
        n.div  = 0;
        n.tick = 1;
        n.msec = s.msec + 1;
        if (n.msec == mm) begin
          n.msec = 0;
          n.sec  = s.sec + 1;
          if (n.sec == sm) begin
            n.sec = 0;
            n.min = s.min + 1;
            if (n.min == nm) begin
              n.min  = 0;
              n.hour = s.hour + 1;
              if (n.hour == hm) n.hour = 0;
            end
          end
        end
      end else begin
        n.div = s.div + 1;
      end
    end
    return n;
  endfunction

  // Drive inputs for the next edge and queue what both instances must show after it.
  task automatic cyc(input bit r, input bit c);
    exp_t e;
    @(negedge clk);
    run_stop = r;
    clear    = c;
    cur_m = nxt(cur_m, 10, 100, 60, 60, 24, r, c);
    cur_s = nxt(cur_s, 2, 4, 3, 2, 2, r, c);
    e.m = cur_m;
    e.s = cur_s;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: pop one expectation per edge once stimulus has queued it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb.msec", msec, e.m.msec);
      check("sb.sec", sec, e.m.sec);
      check("sb.min", min, e.m.min);
      check("sb.hour", hour, e.m.hour);
      check("sb.tick", tick, e.m.tick);
      check("sb.s_msec", s_msec, e.s.msec);
      check("sb.s_sec", s_sec, e.s.sec);
      check("sb.s_min", s_min, e.s.min);
      check("sb.s_hour", s_hour, e.s.hour);
      check("sb.s_tick", s_tick, e.s.tick);
    end
  end

  initial begin
    int ticks;
    int first;

    rst = 1'b1;
    run_stop = 1'b0;
    clear = 1'b0;
    cur_m = '{default: 0};
    cur_s = '{default: 0};
    repeat (3) @(posedge clk);
    #2;
    check("rst.msec", msec, 0);
    check("rst.sec", sec, 0);
    check("rst.min", min, 0);
    check("rst.hour", hour, 0);
    check("rst.tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 100 running edges -> 10 ticks, first at edge 10; the reduced
    //    instance wraps its whole day at edge 96 (3).
    ticks = 0;
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b1, 1'b0);
      after_edge();
      if (tick) begin
        ticks++;
        if (first == 0) first = i;
      end
      if (i == 94) begin
        check("t3.pre_hour", s_hour, 1);
        check("t3.pre_min", s_min, 1);
        check("t3.pre_sec", s_sec, 2);
        check("t3.pre_msec", s_msec, 3);
      end
      if (i == 96) begin
        check("t3.wrap_hour", s_hour, 0);
        check("t3.wrap_min", s_min, 0);
        check("t3.wrap_sec", s_sec, 0);
        check("t3.wrap_msec", s_msec, 0);
        check("t3.wrap_tick", s_tick, 1);
      end
    end
    check("t1.msec", msec, 10);
    check("t1.ticks", ticks, 10);
    check("t1.first", first, 10);

    // 2: advance to 00:00:00.99, then one more tick carries into sec.
    for (int i = 0; i < 890; i++) cyc(1'b1, 1'b0);
    after_edge();
    check("t2.msec99", msec, 99);
    check("t2.sec0", sec, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    after_edge();
    check("t2.msec_wrap", msec, 0);
    check("t2.sec1", sec, 1);
    check("t2.tick", tick, 1);

    // 4: 25 run, 50 hold, resume -> fractional period kept.
    cyc(1'b0, 1'b1);
    ticks = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b1, 1'b0);
      after_edge();
      if (tick) ticks++;
    end
    check("t4.run_ticks", ticks, 2);
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b0);
      after_edge();
      if (tick) ticks++;
    end
    check("t4.hold_msec", msec, 2);
    check("t4.hold_ticks", ticks, 0);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b0);
      after_edge();
      if (tick && first == 0) first = i;
      if (i == 5) check("t4.resume_msec", msec, 3);
    end
    check("t4.resume_first", first, 5);

    // 5: clear exactly on the div==9 edge suppresses the tick.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    after_edge();
    check("t5.clr_msec", msec, 0);
    check("t5.clr_sec", sec, 0);
    check("t5.clr_tick", tick, 0);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1'b0);
      after_edge();
      if (tick && first == 0) first = i;
    end
    check("t5.next_first", first, 10);

    // Stop on the div==9 edge: no tick, resume ticks on the first edge.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    after_edge();
    check("t5b.stop_tick", tick, 0);
    check("t5b.stop_msec", msec, 1);
    cyc(1'b1, 1'b0);
    after_edge();
    check("t5b.resume_tick", tick, 1);
    check("t5b.resume_msec", msec, 2);

    // 6: asynchronous reset between edges.
    for (int i = 0; i < 37; i++) cyc(1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    run_stop = 1'b0;
    #1;
    check("t6.async_msec", msec, 0);
    check("t6.async_sec", sec, 0);
    check("t6.async_tick", tick, 0);
    check("t6.async_s_msec", s_msec, 0);
    cur_m = '{default: 0};
    cur_s = '{default: 0};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b0);
      after_edge();
      if (tick && first == 0) first = i;
    end
    check("t6.restart_msec", msec, 1);
    check("t6.restart_first", first, 10);

    after_edge();
    check("sb.drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
